// File: rtl/ddr_mbus_pkg.sv
// Shared types and helpers for the DDR3 mbus arbiters.
package ddr_mbus_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, never less than 1 so counters always have a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mbus_arb_pick.sv
// Combinational winner selection: round-robin from a pointer, or fixed
// priority where aged requesters pre-empt the lowest-index requester.
module mbus_arb_pick
    import ddr_mbus_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    input  logic [NUM_CH-1:0] aged_i,
    input  logic              mode_i,
    output logic [NUM_CH-1:0] winner_o
);

    logic              found;
    logic [NUM_CH-1:0] aged_req;
    logic [NUM_CH-1:0] cand;

    // One-hot pick; RR uses two passes (from ptr upward, then wrap to 0).
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        aged_req = req_i & aged_i;
        cand     = req_i;
        if (mode_i == MODE_RR) begin
            for (int j = 0; j < int'(NUM_CH); j++) begin
                if (!found && req_i[j] && (j >= int'(ptr_i))) begin
                    winner_o[j] = 1'b1;
                    found       = 1'b1;
                end
            end
            for (int j = 0; j < int'(NUM_CH); j++) begin
                if (!found && req_i[j]) begin
                    winner_o[j] = 1'b1;
                    found       = 1'b1;
                end
            end
        end else begin
            if (|aged_req) cand = aged_req;
            for (int j = 0; j < int'(NUM_CH); j++) begin
                if (!found && cand[j]) begin
                    winner_o[j] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_mbus_wr_arbiter.sv
// N-channel arbiter in front of the single DDR3 write mbus port.
module ddr_mbus_wr_arbiter
    import ddr_mbus_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned MAX_WAIT    = 7,
    parameter int unsigned REQ_TIMEOUT = 1023
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_mode,
    input  logic [NUM_CH-1:0]        i_wrq,
    input  logic [NUM_CH*ADDR_W-1:0] i_waddr,
    input  logic [NUM_CH*DATA_W-1:0] i_wdata,
    input  logic [NUM_CH-1:0]        i_wready,
    output logic [NUM_CH-1:0]        o_wsel,
    output logic                     o_m_wrq,
    output logic [ADDR_W-1:0]        o_m_waddr,
    output logic [DATA_W-1:0]        o_m_wdata,
    output logic                     o_m_wready,
    input  logic                     i_m_wbusy,
    input  logic                     i_m_wdata_rq,
    output logic [NUM_CH-1:0]        o_wdata_rq,
    output logic                     o_timeout
);

    localparam int unsigned PTR_W  = clog2(NUM_CH);
    localparam int unsigned WAIT_W = clog2(MAX_WAIT + 1);
    localparam int unsigned TMO_W  = clog2(REQ_TIMEOUT);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   wsel_q, wsel_d;
    logic                m_wrq_q, m_wrq_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                timeout_q, timeout_d;
    logic [WAIT_W-1:0]   wait_cnt_q [NUM_CH];
    logic [WAIT_W-1:0]   wait_cnt_d [NUM_CH];

    logic [NUM_CH-1:0]   aged;
    logic [NUM_CH-1:0]   winner;
    logic [ADDR_W-1:0]   waddr_win;
    logic                grant;
    int                  win_idx;

    mbus_arb_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req_i    (i_wrq),
        .ptr_i    (ptr_q),
        .aged_i   (aged),
        .mode_i   (i_mode),
        .winner_o (winner)
    );

    // Aged mask, winner index and winner address (AND-OR on one-hot winner).
    always_comb begin
        aged      = '0;
        win_idx   = 0;
        waddr_win = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            aged[k]   = (wait_cnt_q[k] == WAIT_W'(MAX_WAIT));
            if (winner[k]) win_idx = k;
            waddr_win = waddr_win | (i_waddr[k*ADDR_W +: ADDR_W] & {ADDR_W{winner[k]}});
        end
    end

    // FSM next state, grant latching, timeout and anti-starvation counters.
    always_comb begin
        state_d    = state_q;
        wsel_d     = wsel_q;
        m_wrq_d    = m_wrq_q;
        waddr_d    = waddr_q;
        ptr_d      = ptr_q;
        tmo_d      = tmo_q;
        timeout_d  = 1'b0;
        wait_cnt_d = wait_cnt_q;
        grant      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (|i_wrq) begin
                    grant   = 1'b1;
                    state_d = ST_REQ;
                    wsel_d  = winner;
                    m_wrq_d = 1'b1;
                    waddr_d = waddr_win;
                    if (i_mode == MODE_RR) begin
                        ptr_d = (win_idx == int'(NUM_CH) - 1) ? '0 : PTR_W'(win_idx + 1);
                    end
                end
            end
            ST_REQ: begin
                if (i_m_wbusy) begin
                    state_d = ST_XFER;
                    m_wrq_d = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(REQ_TIMEOUT - 1)) begin
                    // Controller never answered: drop the grant, leave wait counters alone.
                    state_d   = ST_IDLE;
                    wsel_d    = '0;
                    m_wrq_d   = 1'b0;
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_XFER: begin
                if (!i_m_wbusy) begin
                    state_d = ST_IDLE;
                    wsel_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wsel_d  = '0;
                m_wrq_d = 1'b0;
            end
        endcase

        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (!i_wrq[k] || (grant && i_mode == MODE_RR)) begin
                wait_cnt_d[k] = '0;
            end else if (grant) begin
                if (winner[k]) begin
                    wait_cnt_d[k] = '0;
                end else if (wait_cnt_q[k] != WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_d[k] = wait_cnt_q[k] + WAIT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            wsel_q    <= '0;
            m_wrq_q   <= 1'b0;
            waddr_q   <= '0;
            ptr_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) wait_cnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            wsel_q     <= wsel_d;
            m_wrq_q    <= m_wrq_d;
            waddr_q    <= waddr_d;
            ptr_q      <= ptr_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Data/ready/data-request steering by the held grant; all zero without a grant.
    always_comb begin
        o_m_wdata  = '0;
        o_m_wready = 1'b0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            o_m_wdata  = o_m_wdata | (i_wdata[k*DATA_W +: DATA_W] & {DATA_W{wsel_q[k]}});
            o_m_wready = o_m_wready | (i_wready[k] & wsel_q[k]);
        end
        o_wdata_rq = wsel_q & {NUM_CH{i_m_wdata_rq}};
    end

    assign o_wsel    = wsel_q;
    assign o_m_wrq   = m_wrq_q;
    assign o_m_waddr = waddr_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_ddr_mbus_wr_arbiter.sv
// Self-checking bench for ddr_mbus_wr_arbiter: table-driven RR/single-channel
// vectors plus hand sequences for aging, timeout, mid-transfer and reset.
module tb_ddr_mbus_wr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 28;
    localparam int DW  = 32;

    logic            clk;
    logic            i_rst;
    logic            i_mode;
    logic [NCH-1:0]  i_wrq;
    logic [NCH*AW-1:0] i_waddr;
    logic [NCH*DW-1:0] i_wdata;
    logic [NCH-1:0]  i_wready;
    logic [NCH-1:0]  o_wsel;
    logic            o_m_wrq;
    logic [AW-1:0]   o_m_waddr;
    logic [DW-1:0]   o_m_wdata;
    logic            o_m_wready;
    logic            i_m_wbusy;
    logic            i_m_wdata_rq;
    logic [NCH-1:0]  o_wdata_rq;
    logic            o_timeout;

    logic [AW-1:0] ch_addr [NCH];
    logic [DW-1:0] ch_data [NCH];

    assign i_waddr = {ch_addr[3], ch_addr[2], ch_addr[1], ch_addr[0]};
    assign i_wdata = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    int errors = 0;
    int checks = 0;

    ddr_mbus_wr_arbiter #(
        .NUM_CH      (NCH),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_WAIT    (3),
        .REQ_TIMEOUT (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_mode       (i_mode),
        .i_wrq        (i_wrq),
        .i_waddr      (i_waddr),
        .i_wdata      (i_wdata),
        .i_wready     (i_wready),
        .o_wsel       (o_wsel),
        .o_m_wrq      (o_m_wrq),
        .o_m_waddr    (o_m_waddr),
        .o_m_wdata    (o_m_wdata),
        .o_m_wready   (o_m_wready),
        .i_m_wbusy    (i_m_wbusy),
        .i_m_wdata_rq (i_m_wdata_rq),
        .o_wdata_rq   (o_wdata_rq),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wrq;
        logic       mode;
        logic       busy;
        int         rep;
        logic [3:0] exp_wsel;
        logic       exp_wrq;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [3:0] wrq, input logic mode, input logic busy, input int rep,
                       input logic [3:0] ew, input logic ewrq);
        vec_t v;
        v.wrq = wrq; v.mode = mode; v.busy = busy; v.rep = rep;
        v.exp_wsel = ew; v.exp_wrq = ewrq;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_wrq = '0;
        i_m_wbusy = 1'b0;
        i_m_wdata_rq = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        i_rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [3:0] sel);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) if (sel[k]) r = r | ch_data[k];
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [3:0] sel);
        logic [AW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) if (sel[k]) r = r | ch_addr[k];
        return r;
    endfunction

    // Wait (bounded) for a grant, check it, run a busy window, check release.
    task automatic xfer(input string name, input logic [3:0] exp_wsel, input int busy_len);
        int n;
        n = 0;
        while (o_m_wrq !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        check({name, " grant"}, o_m_wrq, 1);
        check({name, " wsel"}, o_wsel, exp_wsel);
        i_m_wbusy = 1'b1;
        repeat (busy_len) step();
        i_m_wbusy = 1'b0;
        step();
        check({name, " release"}, o_wsel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_addr[0] = 28'h0000A00; ch_addr[1] = 28'h0000B00;
        ch_addr[2] = 28'h0001000; ch_addr[3] = 28'h0000D00;
        ch_data[0] = 32'hD0D0_0000; ch_data[1] = 32'hD0D0_1111;
        ch_data[2] = 32'hD0D0_2222; ch_data[3] = 32'hD0D0_3333;
        i_wready = 4'b0110;
        i_mode = 1'b0;
        i_rst = 1'b1;
        i_wrq = '0;
        i_m_wbusy = 1'b0;
        i_m_wdata_rq = 1'b0;

        // RR fairness: grants 0,1,2,3,0 with one idle cycle between them.
        for (int g = 0; g < 5; g++) begin
            add(4'b1111, 1'b1, 1'b0, 1, 4'(1 << (g % 4)), 1'b1);
            add(4'b1111, 1'b1, 1'b1, 8, 4'(1 << (g % 4)), 1'b0);
            add(4'b1111, 1'b1, 1'b0, 1, 4'b0000, 1'b0);
        end
        // Single channel, fixed mode; request dropped after grant.
        add(4'b0100, 1'b0, 1'b0, 1,  4'b0100, 1'b1);
        add(4'b0000, 1'b0, 1'b1, 20, 4'b0100, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 1,  4'b0000, 1'b0);
        add(4'b0000, 1'b0, 1'b0, 2,  4'b0000, 1'b0);

        do_reset();
        check("reset wsel", o_wsel, 0);
        check("reset m_wrq", o_m_wrq, 0);
        check("reset waddr", o_m_waddr, 0);
        check("reset wdata", o_m_wdata, 0);
        check("reset wready", o_m_wready, 0);
        check("reset wdata_rq", o_wdata_rq, 0);
        check("reset timeout", o_timeout, 0);

        foreach (tbl[r]) begin
            i_wrq = tbl[r].wrq;
            i_mode = tbl[r].mode;
            i_m_wbusy = tbl[r].busy;
            i_m_wdata_rq = tbl[r].busy;
            for (int n = 0; n < tbl[r].rep; n++) begin
                step();
                check($sformatf("vec%0d.%0d wsel", r, n), o_wsel, tbl[r].exp_wsel);
                check($sformatf("vec%0d.%0d m_wrq", r, n), o_m_wrq, tbl[r].exp_wrq);
                check($sformatf("vec%0d.%0d timeout", r, n), o_timeout, 0);
                check($sformatf("vec%0d.%0d wdata", r, n), o_m_wdata, exp_data(tbl[r].exp_wsel));
                check($sformatf("vec%0d.%0d wready", r, n), o_m_wready,
                      |(tbl[r].exp_wsel & i_wready));
                check($sformatf("vec%0d.%0d wdata_rq", r, n), o_wdata_rq,
                      tbl[r].exp_wsel & {4{tbl[r].busy}});
                if (tbl[r].exp_wsel != 0)
                    check($sformatf("vec%0d.%0d waddr", r, n), o_m_waddr,
                          exp_addr(tbl[r].exp_wsel));
            end
        end
        i_m_wdata_rq = 1'b0;

        // Fixed aging, MAX_WAIT=3: ch0 x3, ch3, then ch0 again.
        do_reset();
        i_mode = 1'b0;
        i_wrq = 4'b1001;
        xfer("age1", 4'b0001, 2);
        xfer("age2", 4'b0001, 2);
        xfer("age3", 4'b0001, 2);
        xfer("age4", 4'b1000, 2);
        xfer("age5", 4'b0001, 2);

        // Timeout after 16 REQ cycles, then a normal regrant.
        i_wrq = 4'b0010;
        step();
        check("tmo grant wsel", o_wsel, 4'b0010);
        check("tmo grant m_wrq", o_m_wrq, 1);
        for (int j = 1; j < 16; j++) begin
            step();
            check($sformatf("tmo hold%0d m_wrq", j), o_m_wrq, 1);
            check($sformatf("tmo hold%0d timeout", j), o_timeout, 0);
        end
        step();
        check("tmo fire m_wrq", o_m_wrq, 0);
        check("tmo fire wsel", o_wsel, 0);
        check("tmo fire pulse", o_timeout, 1);
        step();
        check("tmo pulse end", o_timeout, 0);
        check("tmo regrant wsel", o_wsel, 4'b0010);
        check("tmo regrant m_wrq", o_m_wrq, 1);
        i_wrq = '0;
        i_m_wbusy = 1'b1;
        repeat (3) step();
        i_m_wbusy = 1'b0;
        step();
        check("tmo regrant release", o_wsel, 0);

        // Mid-transfer request drop, address change and mode flip RR -> fixed.
        i_mode = 1'b1;
        i_wrq = 4'b0100;
        step();
        check("mid grant wsel", o_wsel, 4'b0100);
        check("mid grant waddr", o_m_waddr, 28'h0001000);
        i_m_wbusy = 1'b1;
        step();
        i_wrq = '0;
        ch_addr[2] = 28'h0ABCDEF;
        i_mode = 1'b0;
        step();
        check("mid waddr held", o_m_waddr, 28'h0001000);
        check("mid wsel held", o_wsel, 4'b0100);
        repeat (2) step();
        i_m_wbusy = 1'b0;
        step();
        check("mid release", o_wsel, 0);
        ch_addr[2] = 28'h0001000;
        i_wrq = 4'b1001;
        step();
        check("mid new mode fixed", o_wsel, 4'b0001);
        i_wrq = '0;
        i_m_wbusy = 1'b1;
        step();
        i_m_wbusy = 1'b0;
        step();

        // Asynchronous reset during XFER, then RR restarts at ch0.
        i_mode = 1'b1;
        i_wrq = 4'b0010;
        step();
        check("rst pre wsel", o_wsel, 4'b0010);
        i_m_wbusy = 1'b1;
        step();
        check("rst pre wdata", o_m_wdata, 32'hD0D0_1111);
        check("rst pre wready", o_m_wready, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst async wsel", o_wsel, 0);
        check("rst async m_wrq", o_m_wrq, 0);
        check("rst async wdata", o_m_wdata, 0);
        check("rst async wready", o_m_wready, 0);
        i_m_wbusy = 1'b0;
        i_wrq = 4'b1111;
        @(posedge clk);
        #3;
        i_rst = 1'b0;
        step();
        check("rst after ch0 first", o_wsel, 4'b0001);
        check("rst after m_wrq", o_m_wrq, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
